dmem_arbiter: RTL and testbench

Single-port data-memory arbiter that shares the synchronous data RAM between the CPU memory stage and an external requester (UART program loader / debug port). Grants one access per cycle, stalls the losing CPU request, and routes one-cycle-latency read data back to the requester that issued the read. It sits between the CPU's memory stage and the data RAM instance.

---
 rtl/dmem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one synchronous single-port data RAM between the CPU memory stage
//   and an external requester (program loader / debug port). One access is
//   granted per cycle with zero-cycle arbitration; the losing CPU request is
//   stalled. Read data (one-cycle RAM latency) is steered back to whichever
//   side issued the read.
//
// Configuration macro: DMEM_ARB_CPU_PRIO_EN
//   undefined : round-robin tie-break on the last granted owner.
//   defined   : CPU wins ties, except that after STARVE_MAX consecutive
//               ext denials the ext side wins the next tie.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   cpu_req/we/addr/wdata    CPU request (held until granted)
//   cpu_stall                cpu_req & ~cpu_gnt
//   cpu_rdata/cpu_rvalid     CPU read return
//   ext_req/we/addr/wdata    external request
//   ext_gnt                  ext accept strobe
//   ext_rdata/ext_rvalid     ext read return
//   mem_en/we/addr/wdata     RAM command port
//   mem_rdata                RAM read data, valid the cycle after a read
module dmem_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_stall,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [31:0]       ext_wdata,
  output logic              ext_gnt,
  output logic [31:0]       ext_rdata,
  output logic              ext_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_EXT = 1'b1
  } owner_e;

  owner_e      r_rd_owner;
  logic        r_rd_pend;
  logic [31:0] r_cpu_rdata;
  logic [31:0] r_ext_rdata;

  logic w_cpu_gnt;
  logic w_ext_gnt;
  logic w_ext_wins_tie;
  logic w_rd_issue;
  logic w_cpu_ret;
  logic w_ext_ret;

`ifdef DMEM_ARB_CPU_PRIO_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] r_starve_cnt;

  assign w_ext_wins_tie = (r_starve_cnt >= CNT_W'(STARVE_MAX));

  // Counts consecutive cycles the ext side was refused; saturates so it
  // cannot wrap while waiting for the forced grant.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_starve_cnt <= '0;
    end else if (w_ext_gnt) begin
      r_starve_cnt <= '0;
    end else if (ext_req && (r_starve_cnt < CNT_W'(STARVE_MAX))) begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end
  end
`else
  owner_e r_last_owner;

  assign w_ext_wins_tie = (r_last_owner == OWN_CPU);

  // Reset to EXT so the CPU wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last_owner <= OWN_EXT;
    end else if (w_cpu_gnt) begin
      r_last_owner <= OWN_CPU;
    end else if (w_ext_gnt) begin
      r_last_owner <= OWN_EXT;
    end
  end
`endif

  // Grants are forced low while reset is asserted.
  always_comb begin
    w_cpu_gnt = 1'b0;
    w_ext_gnt = 1'b0;
    if (rst) begin
      if (cpu_req && ext_req) begin
        w_ext_gnt = w_ext_wins_tie;
        w_cpu_gnt = !w_ext_wins_tie;
      end else begin
        w_cpu_gnt = cpu_req;
        w_ext_gnt = ext_req;
      end
    end
  end

  assign cpu_stall = cpu_req & ~w_cpu_gnt;
  assign ext_gnt   = w_ext_gnt;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_cpu_gnt) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (w_ext_gnt) begin
      mem_en    = 1'b1;
      mem_we    = ext_we;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
    end
  end

  assign w_rd_issue = (w_cpu_gnt & ~cpu_we) | (w_ext_gnt & ~ext_we);

  // RAM data arrives in the cycle after issue, so the owner's rdata passes
  // mem_rdata straight through on that cycle and a hold register keeps it
  // afterwards. Gating with rst drops a return that lands during reset.
  assign w_cpu_ret  = rst & r_rd_pend & (r_rd_owner == OWN_CPU);
  assign w_ext_ret  = rst & r_rd_pend & (r_rd_owner == OWN_EXT);
  assign cpu_rvalid = w_cpu_ret;
  assign ext_rvalid = w_ext_ret;
  assign cpu_rdata  = w_cpu_ret ? mem_rdata : r_cpu_rdata;
  assign ext_rdata  = w_ext_ret ? mem_rdata : r_ext_rdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_pend   <= 1'b0;
      r_rd_owner  <= OWN_CPU;
      r_cpu_rdata <= '0;
      r_ext_rdata <= '0;
    end else begin
      r_rd_pend <= w_rd_issue;
      if (w_rd_issue) begin
        r_rd_owner <= w_ext_gnt ? OWN_EXT : OWN_CPU;
      end
      if (w_cpu_ret) begin
        r_cpu_rdata <= mem_rdata;
      end
      if (w_ext_ret) begin
        r_ext_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int AW   = 14;
  localparam int SMAX = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [31:0]   cpu_wdata = '0;
  logic          cpu_stall, cpu_rvalid;
  logic [31:0]   cpu_rdata;
  logic          ext_req = 1'b0, ext_we = 1'b0;
  logic [AW-1:0] ext_addr = '0;
  logic [31:0]   ext_wdata = '0;
  logic          ext_gnt, ext_rvalid;
  logic [31:0]   ext_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_arbiter #(.ADDR_W(AW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM attached to the arbiter
  logic [31:0] ram [0:(1<<AW)-1];
  initial for (int k = 0; k < (1 << AW); k++) ram[k] = '0;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endfunction

  task automatic drive(input logic r, input logic cr, input logic cw, input logic [AW-1:0] ca,
                       input logic [31:0] cd, input logic er, input logic ew,
                       input logic [AW-1:0] ea, input logic [31:0] ed);
    @(negedge clk);
    rst = r;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    ext_req = er; ext_we = ew; ext_addr = ea; ext_wdata = ed;
    #2;
  endtask

  typedef struct {
    logic          creq, cwe;
    logic [AW-1:0] caddr;
    logic [31:0]   cwd;
    logic          ereq, ewe;
    logic [AW-1:0] eaddr;
    logic [31:0]   ewd;
    logic          x_stall, x_egnt, x_men, x_mwe;
    logic [AW-1:0] x_maddr;
    logic [31:0]   x_mwd;
    logic          x_rvc;
    logic [31:0]   x_rdc;
    logic          x_rve;
    logic [31:0]   x_rde;
  } vec_t;

  vec_t vt [13];

  // Reference model state for the randomized phase
  logic        m_last_ext;
  int          m_denied;
  logic [31:0] m_shadow [16];
  logic        m_pend, m_pend_cpu;
  logic [31:0] m_pend_data, m_cpu_hold, m_ext_hold;

  initial begin
    // ---------------- reset state ----------------
    drive(1'b0, 1'b1, 1'b0, 14'd0, 32'd0, 1'b1, 1'b0, 14'd0, 32'd0);
    drive(1'b0, 1'b1, 1'b0, 14'd0, 32'd0, 1'b1, 1'b0, 14'd0, 32'd0);
    chk("rst mem_en", 32'(mem_en), 32'd0);
    chk("rst ext_gnt", 32'(ext_gnt), 32'd0);
    chk("rst cpu_stall", 32'(cpu_stall), 32'd1);
    chk("rst cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("rst ext_rvalid", 32'(ext_rvalid), 32'd0);
    chk("rst cpu_rdata", cpu_rdata, 32'd0);
    chk("rst ext_rdata", ext_rdata, 32'd0);

    // ---------------- table-driven vectors ----------------
    //            creq  cwe   caddr  cwd           ereq  ewe   eaddr  ewd             stall egnt  men   mwe   maddr  mwd            rvc   rdc            rve   rde
    vt[0]  = '{1'b1, 1'b1, 14'd5, 32'h0000_00AB, 1'b0, 1'b0, 14'd0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 14'd5, 32'h0000_00AB, 1'b0, 32'h0,         1'b0, 32'h0};
    vt[1]  = '{1'b1, 1'b0, 14'd5, 32'h0,         1'b0, 1'b0, 14'd0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 14'd5, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
    vt[2]  = '{1'b0, 1'b0, 14'd0, 32'h0,         1'b0, 1'b0, 14'd0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 14'd0, 32'h0,         1'b1, 32'h0000_00AB, 1'b0, 32'h0};
    vt[3]  = '{1'b1, 1'b1, 14'd1, 32'h11,        1'b0, 1'b0, 14'd0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 14'd1, 32'h11,        1'b0, 32'h0000_00AB, 1'b0, 32'h0};
    vt[4]  = '{1'b1, 1'b1, 14'd2, 32'h22,        1'b0, 1'b0, 14'd0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 14'd2, 32'h22,        1'b0, 32'h0000_00AB, 1'b0, 32'h0};
    vt[5]  = '{1'b1, 1'b0, 14'd1, 32'h0,         1'b0, 1'b0, 14'd0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 14'd1, 32'h0,         1'b0, 32'h0000_00AB, 1'b0, 32'h0};
    vt[6]  = '{1'b1, 1'b0, 14'd2, 32'h0,         1'b0, 1'b0, 14'd0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 14'd2, 32'h0,         1'b1, 32'h11,        1'b0, 32'h0};
    vt[7]  = '{1'b0, 1'b0, 14'd0, 32'h0,         1'b0, 1'b0, 14'd0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 14'd0, 32'h0,         1'b1, 32'h22,        1'b0, 32'h0};
    vt[8]  = '{1'b0, 1'b0, 14'd0, 32'h0,         1'b1, 1'b1, 14'd3, 32'h0000_CAFE, 1'b0, 1'b1, 1'b1, 1'b1, 14'd3, 32'h0000_CAFE, 1'b0, 32'h22,        1'b0, 32'h0};
    vt[9]  = '{1'b0, 1'b0, 14'd0, 32'h0,         1'b1, 1'b0, 14'd3, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 14'd3, 32'h0,         1'b0, 32'h22,        1'b0, 32'h0};
    vt[10] = '{1'b0, 1'b0, 14'd0, 32'h0,         1'b0, 1'b0, 14'd0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 14'd0, 32'h0,         1'b0, 32'h22,        1'b1, 32'h0000_CAFE};
    vt[11] = '{1'b1, 1'b0, 14'd3, 32'h0,         1'b0, 1'b0, 14'd0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 14'd3, 32'h0,         1'b0, 32'h22,        1'b0, 32'h0000_CAFE};
    vt[12] = '{1'b0, 1'b0, 14'd0, 32'h0,         1'b1, 1'b1, 14'd4, 32'h44,        1'b0, 1'b1, 1'b1, 1'b1, 14'd4, 32'h44,        1'b1, 32'h0000_CAFE, 1'b0, 32'h0000_CAFE};

    for (int i = 0; i < 13; i++) begin
      drive(1'b1, vt[i].creq, vt[i].cwe, vt[i].caddr, vt[i].cwd,
            vt[i].ereq, vt[i].ewe, vt[i].eaddr, vt[i].ewd);
      chk($sformatf("row%0d cpu_stall", i), 32'(cpu_stall), 32'(vt[i].x_stall));
      chk($sformatf("row%0d ext_gnt", i), 32'(ext_gnt), 32'(vt[i].x_egnt));
      chk($sformatf("row%0d mem_en", i), 32'(mem_en), 32'(vt[i].x_men));
      chk($sformatf("row%0d mem_we", i), 32'(mem_we), 32'(vt[i].x_mwe));
      chk($sformatf("row%0d mem_addr", i), 32'(mem_addr), 32'(vt[i].x_maddr));
      chk($sformatf("row%0d mem_wdata", i), mem_wdata, vt[i].x_mwd);
      chk($sformatf("row%0d cpu_rvalid", i), 32'(cpu_rvalid), 32'(vt[i].x_rvc));
      chk($sformatf("row%0d cpu_rdata", i), cpu_rdata, vt[i].x_rdc);
      chk($sformatf("row%0d ext_rvalid", i), 32'(ext_rvalid), 32'(vt[i].x_rve));
      chk($sformatf("row%0d ext_rdata", i), ext_rdata, vt[i].x_rde);
    end

    // ---------------- both requesting continuously ----------------
    // Last owner is EXT here (row 12), starve count is 0.
    for (int i = 0; i < 18; i++) begin
      logic ew_exp;
`ifdef DMEM_ARB_CPU_PRIO_EN
      ew_exp = ((i % (SMAX + 1)) == SMAX);
`else
      ew_exp = ((i % 2) == 1);
`endif
      drive(1'b1, 1'b1, 1'b1, 14'd30, 32'(100 + i), 1'b1, 1'b1, 14'd31, 32'(200 + i));
      chk($sformatf("tie%0d cpu_stall", i), 32'(cpu_stall), 32'(ew_exp));
      chk($sformatf("tie%0d ext_gnt", i), 32'(ext_gnt), 32'(ew_exp));
      chk($sformatf("tie%0d mem_addr", i), 32'(mem_addr), ew_exp ? 32'd31 : 32'd30);
    end

    // ---------------- reset during a pending ext read ----------------
    drive(1'b1, 1'b0, 1'b0, 14'd0, 32'd0, 1'b1, 1'b0, 14'd4, 32'd0);
    chk("prerst ext_gnt", 32'(ext_gnt), 32'd1);
    drive(1'b0, 1'b1, 1'b0, 14'd0, 32'd0, 1'b1, 1'b0, 14'd4, 32'd0);
    chk("inrst ext_rvalid", 32'(ext_rvalid), 32'd0);
    chk("inrst mem_en", 32'(mem_en), 32'd0);
    chk("inrst ext_gnt", 32'(ext_gnt), 32'd0);
    chk("inrst cpu_stall", 32'(cpu_stall), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 14'd0, 32'd0, 1'b0, 1'b0, 14'd0, 32'd0);
    chk("inrst2 ext_rdata", ext_rdata, 32'd0);
    chk("inrst2 cpu_rdata", cpu_rdata, 32'd0);

    // ---------------- same-address hazard, first tie after reset ----------------
    drive(1'b1, 1'b1, 1'b0, 14'd9, 32'd0, 1'b1, 1'b1, 14'd9, 32'h1234_5678);
    chk("haz0 cpu_stall", 32'(cpu_stall), 32'd0);
    chk("haz0 ext_gnt", 32'(ext_gnt), 32'd0);
    chk("haz0 mem_we", 32'(mem_we), 32'd0);
    chk("haz0 mem_addr", 32'(mem_addr), 32'd9);
    chk("haz0 ext_rvalid", 32'(ext_rvalid), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 14'd0, 32'd0, 1'b1, 1'b1, 14'd9, 32'h1234_5678);
    chk("haz1 ext_gnt", 32'(ext_gnt), 32'd1);
    chk("haz1 mem_we", 32'(mem_we), 32'd1);
    chk("haz1 cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("haz1 cpu_rdata old", cpu_rdata, 32'd0);
    chk("haz1 ext_rvalid", 32'(ext_rvalid), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 14'd9, 32'd0, 1'b0, 1'b0, 14'd0, 32'd0);
    chk("haz2 cpu_stall", 32'(cpu_stall), 32'd0);
    chk("haz2 mem_addr", 32'(mem_addr), 32'd9);
    drive(1'b1, 1'b0, 1'b0, 14'd0, 32'd0, 1'b0, 1'b0, 14'd0, 32'd0);
    chk("haz3 cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("haz3 cpu_rdata new", cpu_rdata, 32'h1234_5678);

    // ---------------- randomized phase against reference model ----------------
    drive(1'b0, 1'b0, 1'b0, 14'd0, 32'd0, 1'b0, 1'b0, 14'd0, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 14'd0, 32'd0, 1'b0, 1'b0, 14'd0, 32'd0);
    m_last_ext = 1'b1;
    m_denied   = 0;
    m_pend     = 1'b0;
    m_pend_cpu = 1'b0;
    m_pend_data = '0;
    m_cpu_hold = '0;
    m_ext_hold = '0;
    for (int k = 0; k < 16; k++) m_shadow[k] = '0;

    for (int i = 0; i < 300; i++) begin
      logic cr, cw, er, ew, cpu_win, ext_win, tie_ext;
      int ci, ei;
      logic [31:0] cd, ed, x_crd, x_erd;
      cr = ($urandom_range(0, 9) < 8);
      er = ($urandom_range(0, 9) < 6);
      cw = 1'($urandom_range(0, 1));
      ew = 1'($urandom_range(0, 1));
      ci = $urandom_range(0, 15);
      ei = $urandom_range(0, 15);
      cd = $urandom;
      ed = $urandom;
      drive(1'b1, cr, cw, 14'(64 + ci), cd, er, ew, 14'(64 + ei), ed);

`ifdef DMEM_ARB_CPU_PRIO_EN
      tie_ext = (m_denied >= SMAX);
`else
      tie_ext = m_last_ext;
      tie_ext = ~tie_ext;
`endif
      ext_win = er && (!cr || tie_ext);
      cpu_win = cr && !ext_win;

      chk("rnd cpu_stall", 32'(cpu_stall), 32'(cr && !cpu_win));
      chk("rnd ext_gnt", 32'(ext_gnt), 32'(ext_win));
      chk("rnd mem_en", 32'(mem_en), 32'(cpu_win || ext_win));
      chk("rnd mem_we", 32'(mem_we), cpu_win ? 32'(cw) : ext_win ? 32'(ew) : 32'd0);
      chk("rnd mem_addr", 32'(mem_addr), cpu_win ? 32'(64 + ci) : ext_win ? 32'(64 + ei) : 32'd0);
      chk("rnd mem_wdata", mem_wdata, cpu_win ? cd : ext_win ? ed : 32'd0);

      x_crd = (m_pend && m_pend_cpu) ? m_pend_data : m_cpu_hold;
      x_erd = (m_pend && !m_pend_cpu) ? m_pend_data : m_ext_hold;
      chk("rnd cpu_rvalid", 32'(cpu_rvalid), 32'(m_pend && m_pend_cpu));
      chk("rnd ext_rvalid", 32'(ext_rvalid), 32'(m_pend && !m_pend_cpu));
      chk("rnd cpu_rdata", cpu_rdata, x_crd);
      chk("rnd ext_rdata", ext_rdata, x_erd);
      m_cpu_hold = x_crd;
      m_ext_hold = x_erd;

      m_pend = 1'b0;
      if (cpu_win) begin
        if (cw) m_shadow[ci] = cd;
        else begin m_pend = 1'b1; m_pend_cpu = 1'b1; m_pend_data = m_shadow[ci]; end
        m_last_ext = 1'b0;
      end else if (ext_win) begin
        if (ew) m_shadow[ei] = ed;
        else begin m_pend = 1'b1; m_pend_cpu = 1'b0; m_pend_data = m_shadow[ei]; end
        m_last_ext = 1'b1;
      end
      if (ext_win) m_denied = 0;
      else if (er) m_denied = m_denied + 1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
